// File: rtl/segment_pkg.sv
// Shared types for the segment register file port arbiter.
// Segment select encoding, data width and lock FSM states.
package segment_pkg;

    localparam int SR_W = 16;

    typedef enum logic [1:0] {
        ES = 2'd0,
        CS = 2'd1,
        SS = 2'd2,
        DS = 2'd3
    } SR_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin picker: scans req&mask from ptr upward, modulo NUM_REQ.
// Ports: req, ptr, mask in; one-hot grant, winner index, found out.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   winner,
    output logic               found
);

    int idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx] && mask[idx]) begin
                found      = 1'b1;
                winner     = IDX_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/segment_port_arbiter.sv
// Shares the segment register file read/write ports among NUM_REQ requesters
// with round-robin priority, a multi-access lock and read-response routing.
// Ports: req_* per-requester handshake in, req_ready/rsp_* back to requesters,
// sr_* to/from the register file, ss_loaded pulse, owner/locked lock status.
module segment_port_arbiter
    import segment_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int SR_W = segment_pkg::SR_W,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ-1:0]      req_lock,
    input  logic [2*NUM_REQ-1:0]    req_sel,
    input  logic [SR_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [SR_W-1:0]         rsp_data,
    output logic [1:0]              sr_rd_sel,
    input  logic [SR_W-1:0]         sr_rd_val,
    output logic                    sr_wr_en,
    output logic [1:0]              sr_wr_sel,
    output logic [SR_W-1:0]         sr_wr_val,
    output logic                    ss_loaded,
    output logic [IDX_W-1:0]        owner,
    output logic                    locked
);

    lock_state_t         state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    winner;
    logic [NUM_REQ-1:0]  mask, grant, rsp_q;
    logic                found, grant_ok, rd_grant, wr_grant;
    logic                win_write, win_lock, ss_q;
    logic [1:0]          win_sel, rd_sel_q;
    logic [SR_W-1:0]     win_wdata;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // While locked only the owner is eligible.
    always_comb begin
        mask = '1;
        if (state_q == LOCKED) mask = NUM_REQ'(1) << owner_q;
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req    (req_valid),
        .ptr    (ptr_q),
        .mask   (mask),
        .grant  (grant),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        win_write = req_write[winner];
        win_lock  = req_lock[winner];
        win_sel   = req_sel[int'(winner)*2 +: 2];
        win_wdata = req_wdata[int'(winner)*SR_W +: SR_W];
    end

    assign grant_ok = found & ~reset;
    assign wr_grant = grant_ok & win_write;
    assign rd_grant = grant_ok & ~win_write;

    assign req_ready = grant_ok ? grant : '0;
    assign sr_wr_en  = wr_grant;
    assign sr_wr_sel = wr_grant ? win_sel : 2'b00;
    assign sr_wr_val = wr_grant ? win_wdata : '0;

    // Read select holds its last value between read grants.
    assign sr_rd_sel = reset ? 2'b00 : (rd_grant ? win_sel : rd_sel_q);

    // Reset masks a response already in flight.
    assign rsp_valid = reset ? '0 : rsp_q;
    assign rsp_data  = (reset || rsp_q == '0) ? '0 : sr_rd_val;

    assign ss_loaded = ss_q & ~reset;
    assign locked    = (state_q == LOCKED) & ~reset;
    assign owner     = reset ? '0 : owner_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (grant_ok) begin
            unique case (state_q)
                UNLOCKED: begin
                    ptr_d = next_idx(winner);
                    if (win_lock) begin
                        state_d = LOCKED;
                        owner_d = winner;
                    end
                end
                LOCKED: begin
                    if (!win_lock) begin
                        state_d = UNLOCKED;
                        ptr_d   = next_idx(owner_q);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= UNLOCKED;
            ptr_q    <= '0;
            owner_q  <= '0;
            rsp_q    <= '0;
            ss_q     <= 1'b0;
            rd_sel_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            rsp_q    <= rd_grant ? grant : '0;
            ss_q     <= wr_grant && (win_sel == SS);
            if (rd_grant) rd_sel_q <= win_sel;
        end
    end

endmodule

// File: tb/tb_segment_port_arbiter.sv
// Directed bench for segment_port_arbiter with a cycle-level reference model
// of arbitration, lock ownership, responses and a modelled register file.
module tb_segment_port_arbiter;

    localparam int N = 3;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_write = '0;
    logic [N-1:0]   req_lock = '0;
    logic [2*N-1:0] req_sel = '0;
    logic [W*N-1:0] req_wdata = '0;
    logic [N-1:0]   req_ready, rsp_valid;
    logic [W-1:0]   rsp_data, sr_wr_val;
    logic [W-1:0]   sr_rd_val = '0;
    logic [1:0]     sr_rd_sel, sr_wr_sel;
    logic           sr_wr_en, ss_loaded, locked;
    logic [1:0]     owner;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    segment_port_arbiter #(.NUM_REQ(N), .SR_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_lock  (req_lock),
        .req_sel   (req_sel),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .sr_rd_sel (sr_rd_sel),
        .sr_rd_val (sr_rd_val),
        .sr_wr_en  (sr_wr_en),
        .sr_wr_sel (sr_wr_sel),
        .sr_wr_val (sr_wr_val),
        .ss_loaded (ss_loaded),
        .owner     (owner),
        .locked    (locked)
    );

    // Environment register file driven by the DUT ports.
    logic [W-1:0] rf [4];
    always @(posedge clk) begin
        if (sr_wr_en) rf[sr_wr_sel] <= sr_wr_val;
        sr_rd_val <= rf[sr_rd_sel];
    end

    // Reference model state.
    int           m_ptr = 0;
    int           m_owner = 0;
    int           m_pend = -1;
    bit           m_locked = 0;
    bit           m_ss = 0;
    logic [W-1:0] m_pend_data = '0;
    logic [1:0]   m_rdsel = 2'b00;
    logic [W-1:0] m_rf [4];

    function automatic int m_winner();
        int i;
        if (reset) return -1;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (req_valid[i] && (!m_locked || i == m_owner)) return i;
        end
        return -1;
    endfunction

    function automatic logic [1:0] sel_of(int i);
        return req_sel[2*i +: 2];
    endfunction

    function automatic logic [W-1:0] wdata_of(int i);
        return req_wdata[W*i +: W];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int w;
        bit wr;
        logic [31:0] e;
        w = m_winner();
        wr = (w >= 0) && req_write[w];
        e = (w >= 0) ? (32'd1 << w) : 32'd0;
        chk("m_ready", 32'(req_ready), e);
        chk("m_wr_en", 32'(sr_wr_en), 32'(wr));
        if (wr) begin
            chk("m_wr_sel", 32'(sr_wr_sel), 32'(sel_of(w)));
            chk("m_wr_val", 32'(sr_wr_val), 32'(wdata_of(w)));
        end
        if (reset) e = 0;
        else if (w >= 0 && !wr) e = 32'(sel_of(w));
        else e = 32'(m_rdsel);
        chk("m_rd_sel", 32'(sr_rd_sel), e);
        e = (!reset && m_pend >= 0) ? (32'd1 << m_pend) : 32'd0;
        chk("m_rsp_valid", 32'(rsp_valid), e);
        if (reset) chk("m_rsp_data_rst", 32'(rsp_data), 32'd0);
        else if (m_pend >= 0) chk("m_rsp_data", 32'(rsp_data), 32'(m_pend_data));
        chk("m_ss_loaded", 32'(ss_loaded), 32'(!reset && m_ss));
        chk("m_locked", 32'(locked), 32'(!reset && m_locked));
        if (!reset && m_locked) chk("m_owner", 32'(owner), 32'(m_owner));
        if (reset) chk("m_owner_rst", 32'(owner), 32'd0);
    endtask

    task automatic model_update();
        int w;
        if (reset) begin
            m_ptr = 0; m_owner = 0; m_pend = -1;
            m_locked = 0; m_ss = 0; m_rdsel = 2'b00;
            return;
        end
        w = m_winner();
        m_pend = -1;
        m_ss = 0;
        if (w < 0) return;
        if (req_write[w]) begin
            m_rf[sel_of(w)] = wdata_of(w);
            m_ss = (sel_of(w) == 2'd2);
        end else begin
            m_pend = w;
            m_pend_data = m_rf[sel_of(w)];
            m_rdsel = sel_of(w);
        end
        if (!m_locked) begin
            m_ptr = (w + 1) % N;
            if (req_lock[w]) begin
                m_locked = 1;
                m_owner = w;
            end
        end else if (!req_lock[w]) begin
            m_locked = 0;
            m_ptr = (w + 1) % N;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        check_model();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_req(int i, bit w, bit l, logic [1:0] s, logic [W-1:0] d);
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_lock[i] = l;
        req_sel[2*i +: 2] = s;
        req_wdata[W*i +: W] = d;
    endtask

    task automatic drop(int i);
        req_valid[i] = 1'b0;
        req_lock[i] = 1'b0;
    endtask

    initial begin
        rf[0] = 16'h00E5; rf[1] = 16'h00C5; rf[2] = 16'h0055; rf[3] = 16'h1234;
        for (int i = 0; i < 4; i++) m_rf[i] = rf[i];

        // Reset held two cycles with everyone requesting.
        set_req(0, 0, 0, 2'd3, 16'h0);
        set_req(1, 0, 0, 2'd1, 16'h0);
        set_req(2, 0, 0, 2'd0, 16'h0);
        for (int c = 0; c < 2; c++) begin
            at_neg();
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_wr_en", 32'(sr_wr_en), 32'd0);
            chk("rst_rsp", 32'(rsp_valid), 32'd0);
            adv();
        end
        reset = 1'b0;

        // Round robin reads.
        at_neg();
        chk("rr_g0", 32'(req_ready), 32'b001);
        chk("rr_rdsel", 32'(sr_rd_sel), 32'd3);
        adv();
        at_neg();
        chk("rr_g1", 32'(req_ready), 32'b010);
        chk("rr_rsp0", 32'(rsp_valid), 32'b001);
        chk("rr_data0", 32'(rsp_data), 32'h1234);
        adv();
        at_neg();
        chk("rr_g2", 32'(req_ready), 32'b100);
        chk("rr_data1", 32'(rsp_data), 32'h00C5);
        adv();
        at_neg();
        chk("rr_g0b", 32'(req_ready), 32'b001);
        chk("rr_rsp2", 32'(rsp_valid), 32'b100);
        adv();
        at_neg();
        adv();
        req_valid = '0;
        at_neg();
        chk("rr_idle", 32'(req_ready), 32'd0);
        adv();

        // Write SS then read it back.
        set_req(1, 1, 0, 2'd2, 16'hBEEF);
        at_neg();
        chk("wr_ready", 32'(req_ready), 32'b010);
        chk("wr_sel", 32'(sr_wr_sel), 32'd2);
        chk("wr_val", 32'(sr_wr_val), 32'hBEEF);
        adv();
        drop(1);
        set_req(0, 0, 0, 2'd2, 16'h0);
        at_neg();
        chk("ss_pulse", 32'(ss_loaded), 32'd1);
        chk("raw_ready", 32'(req_ready), 32'b001);
        adv();
        drop(0);
        at_neg();
        chk("raw_data", 32'(rsp_data), 32'hBEEF);
        chk("ss_once", 32'(ss_loaded), 32'd0);
        adv();

        // Lock held by requester 2.
        set_req(2, 1, 1, 2'd1, 16'hF000);
        at_neg();
        chk("lk_ready", 32'(req_ready), 32'b100);
        adv();
        drop(2);
        set_req(0, 0, 0, 2'd0, 16'h0);
        set_req(1, 0, 0, 2'd3, 16'h0);
        at_neg();
        chk("lk_stall", 32'(req_ready), 32'd0);
        chk("lk_owner", 32'(owner), 32'd2);
        adv();
        set_req(2, 1, 0, 2'd1, 16'hF00F);
        at_neg();
        chk("lk_rel", 32'(req_ready), 32'b100);
        adv();
        drop(2);
        at_neg();
        chk("lk_after", 32'(req_ready), 32'b001);
        chk("lk_unl", 32'(locked), 32'd0);
        adv();
        drop(0);
        at_neg();
        adv();
        drop(1);
        at_neg();
        adv();

        // Idle owner keeps the lock.
        set_req(1, 1, 1, 2'd3, 16'h4321);
        at_neg();
        chk("io_grant", 32'(req_ready), 32'b010);
        adv();
        drop(1);
        set_req(0, 0, 0, 2'd0, 16'h0);
        set_req(2, 0, 0, 2'd0, 16'h0);
        for (int c = 0; c < 5; c++) begin
            at_neg();
            chk("io_stall", 32'(req_ready), 32'd0);
            chk("io_owner", 32'(owner), 32'd1);
            adv();
        end
        set_req(1, 0, 0, 2'd2, 16'h0);
        at_neg();
        chk("io_rel", 32'(req_ready), 32'b010);
        adv();
        drop(1);
        at_neg();
        chk("io_next", 32'(req_ready), 32'b100);
        chk("io_data", 32'(rsp_data), 32'hBEEF);
        adv();
        drop(2);
        at_neg();
        adv();
        drop(0);
        at_neg();
        adv();

        // Reset in the response cycle of a locking read.
        set_req(0, 0, 1, 2'd1, 16'h0);
        at_neg();
        chk("rm_grant", 32'(req_ready), 32'b001);
        adv();
        drop(0);
        reset = 1'b1;
        at_neg();
        chk("rm_rsp", 32'(rsp_valid), 32'd0);
        adv();
        reset = 1'b0;
        at_neg();
        chk("rm_rsp2", 32'(rsp_valid), 32'd0);
        chk("rm_unl", 32'(locked), 32'd0);
        adv();
        set_req(0, 0, 0, 2'd1, 16'h0);
        set_req(1, 0, 0, 2'd2, 16'h0);
        at_neg();
        chk("rm_ptr0", 32'(req_ready), 32'b001);
        adv();
        req_valid = '0;
        at_neg();
        chk("rm_data", 32'(rsp_data), 32'hF00F);
        adv();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/segment_port_arbiter.md
Name: segment_port_arbiter

Overview:
- Shares the segment register file's single read port and single write port among NUM_REQ requesters, for example the microcode execution path, the interrupt/far-transfer sequencer and the debug port.
- Grants one access per cycle using round-robin priority.
- Supports a lock so a requester can perform an atomic multi-access sequence, such as an interrupt push of CS followed by a load of CS.
- Routes the one-cycle-latency read data back to the requester that issued the read.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- SR_W, 16, segment register data width.

Ports:
- clk  in  1  single clock for the block.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- req_valid  in  NUM_REQ  per-requester access request.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  holds ownership after this grant.
- req_sel  in  2*NUM_REQ  segment select per requester; encoding ES=0, CS=1, SS=2, DS=3.
- req_wdata  in  SR_W*NUM_REQ  write data per requester.
- req_ready  out  NUM_REQ  one-hot grant (combinational).
- rsp_valid  out  NUM_REQ  one-hot read-data-valid.
- rsp_data  out  SR_W  shared read data bus.
- sr_rd_sel  out  2  to register file read select.
- sr_rd_val  in  SR_W  from register file; registered one cycle after sr_rd_sel.
- sr_wr_en  out  1  to register file write enable.
- sr_wr_sel  out  2  to register file write select.
- sr_wr_val  out  SR_W  to register file write data.
- ss_loaded  out  1  registered pulse, one cycle after an SS write commits (interrupt-inhibit source for the core).
- owner  out  $clog2(NUM_REQ)  current lock owner; valid while locked.
- locked  out  1  a lock is held.

Behaviour:
- Requester handshake:
  - req_valid, req_write, req_sel and req_wdata stay stable until req_ready is seen high.
  - A transfer occurs at the posedge where both req_valid[i] and req_ready[i] are high.
  - req_ready is at most one-hot. It is a combinational function of req_valid, the priority pointer and the lock state.
- Round-robin arbitration:
  - Pointer ptr names the highest-priority requester. ptr = 0 after reset.
  - The winner is the first i with req_valid[i] set, scanning ptr, ptr+1, … modulo NUM_REQ.
  - On any grant outside a lock, ptr <= winner+1, wrapping to 0 past NUM_REQ-1.
- Write grant:
  - sr_wr_en=1, sr_wr_sel=req_sel[i], sr_wr_val=req_wdata[i], all combinational in the grant cycle.
  - The register file updates at that edge.
  - If sr_wr_sel==SS (2), ss_loaded=1 in the next cycle only.
- Read grant:
  - sr_rd_sel=req_sel[i] in the grant cycle.
  - Next cycle: rsp_valid[i]=1 and rsp_data=sr_rd_val, for exactly one cycle.
  - A read granted in cycle n+1 gets its response in cycle n+2; back-to-back reads give one response per cycle.
- sr_rd_sel holds its last value when no read is granted. sr_wr_en=0 when no write is granted.
- Read-after-write across grants sees the new value, because the file has updated by then.
- Lock state machine, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED when a granted request has req_lock=1. owner <= winner.
  - In LOCKED, only owner can be granted, whenever req_valid[owner]=1; other requesters stall with req_ready=0.
  - LOCKED -> UNLOCKED on a granted owner request with req_lock=0. ptr <= owner+1.
  - An idle owner (req_valid=0) keeps the lock indefinitely. No timeout.
- Reset:
  - All outputs go to 0: req_ready, rsp_valid, rsp_data, sr_wr_en, sr_rd_sel, ss_loaded, locked, owner.
  - State returns to UNLOCKED, ptr=0.
  - Reset during a pending read drops the response; rsp_valid stays 0 in the following cycle.
  - No write is issued while reset is high.
- With no req_valid set, there is no grant and state is unchanged.

Decomposition:
- Package segment_pkg holds:
  - SR_t enum (ES, CS, SS, DS = 0..3);
  - SR_W;
  - lock_state_t enum (UNLOCKED, LOCKED).
- Sub-module rr_arbiter (generic NUM_REQ round-robin picker):
  - inputs: req vector, ptr, mask;
  - outputs: one-hot grant and winner index.
- The top level owns the lock FSM, the pointer update, the read-response pipeline and the register-file port muxing.

Test Plan:
- Reset: all three requesters valid, reset held 2 cycles -> no req_ready, sr_wr_en=0, rsp_valid=0. First cycle after release grants requester 0.
- Round robin: req0..2 read continuously, selects DS/CS/ES -> grants 0,1,2,0,… Each rsp_valid[i] arrives one cycle after its grant, carrying the file contents (e.g. DS=0x1234 to req0).
- Write then read: req1 writes SS=0xBEEF, then req0 reads SS -> sr_wr_en with sel=2 in the grant cycle, ss_loaded pulses the next cycle, and req0's rsp_data=0xBEEF.
- Lock: req2 writes CS=0xF000 with lock=1 while req0 and req1 are valid -> req0/req1 stall. req2's next write (lock=0) is granted, then req0 is granted next (ptr=0 after wrap).
- Idle owner: req1 holds lock with req_valid low for 5 cycles -> no grants to others, locked=1, owner=1.
- Reset mid-read: reset asserted in the cycle after a read grant -> rsp_valid stays 0 and the FSM is UNLOCKED after release.
